// File: rtl/seg7_apb_scan_ctrl.sv
// APB3 slave for a multiplexed common-anode 7-segment display with PWM dimming.
// Optional decimal-point support is enabled by defining SEG7_DP_EN.
module seg7_apb_scan_ctrl #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 1024
) (
    input  logic              pclk_i,
    input  logic              preset_i,
    input  logic [31:0]       paddr_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [31:0]       pwdata_i,
    input  logic [3:0]        pstrb_i,
    output logic              pready_o,
    output logic [31:0]       prdata_o,
    output logic              pslverr_o,
    output logic [6:0]        seg_o,
`ifdef SEG7_DP_EN
    output logic              dp_o,
`endif
    output logic [DIGITS-1:0] an_o
);

    localparam int          PW    = $clog2(SCAN_DIV);
    localparam logic [31:0] DMASK = 32'hFFFF_FFFF >> (32 - 4 * DIGITS);
    localparam logic [7:0]  MMASK = 8'hFF >> (8 - DIGITS);
    localparam logic [2:0]  LAST  = 3'(DIGITS - 1);

    logic [31:0]       data_q, data_d;
    logic              en_q, en_d;
    logic [3:0]        bright_q, bright_d;
    logic              srst_q, srst_d;
    logic [7:0]        blank_q, blank_d;
    logic [7:0]        dp_q, dp_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [2:0]        idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dpo_q, dpo_d;

    logic        access, err, wr, active;
    logic [2:0]  word;
    logic [31:0] rdata, wmask;
    logic [3:0]  cur;
    logic        dp_absent;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign access   = psel_i & penable_i;
    assign pready_o = access;
    assign word     = paddr_i[4:2];
    assign wmask    = {{8{pstrb_i[3]}}, {8{pstrb_i[2]}},
                       {8{pstrb_i[1]}}, {8{pstrb_i[0]}}};

`ifdef SEG7_DP_EN
    assign dp_absent = 1'b0;
`else
    assign dp_absent = (word == 3'd2);
`endif

    always_comb begin
        err = (|paddr_i[31:5]) | (|paddr_i[1:0]) | (word > 3'd4)
            | (pwrite_i & (word == 3'd4)) | dp_absent;
    end

    assign wr        = access & pwrite_i & ~err;
    assign pslverr_o = access & err;

    always_comb begin
        rdata = 32'h0;
        case (word)
            3'd0: rdata = data_q;
            3'd1: rdata = {24'h0, bright_q, 2'b00, 1'b0, en_q};
            3'd2: rdata = {24'h0, dp_q};
            3'd3: rdata = {24'h0, blank_q};
            3'd4: rdata = {28'h0, ~(&an_q), idx_q};
            default: rdata = 32'h0;
        endcase
        prdata_o = (access & ~err) ? rdata : 32'h0;
    end

    // Register file; a pending SRST wipes the display contents one cycle later.
    always_comb begin
        data_d   = data_q;
        en_d     = en_q;
        bright_d = bright_q;
        srst_d   = 1'b0;
        blank_d  = blank_q;
        dp_d     = dp_q;
        if (srst_q) begin
            data_d  = 32'h0;
            blank_d = 8'h0;
            dp_d    = 8'h0;
        end
        if (wr) begin
            case (word)
                3'd0: data_d = ((data_q & ~wmask) | (pwdata_i & wmask)) & DMASK;
                3'd1: if (pstrb_i[0]) begin
                    en_d     = pwdata_i[0];
                    srst_d   = pwdata_i[1];
                    bright_d = pwdata_i[7:4];
                end
`ifdef SEG7_DP_EN
                3'd2: if (pstrb_i[0]) dp_d = pwdata_i[7:0] & MMASK;
`endif
                3'd3: if (pstrb_i[0]) blank_d = pwdata_i[7:0] & MMASK;
                default: ;
            endcase
        end
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (!en_q || srst_q) begin
            presc_d = '0;
            idx_d   = 3'd0;
        end else if (&presc_q) begin
            idx_d = (idx_q == LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_comb begin
        cur    = data_q[{idx_q, 2'b00} +: 4];
        active = en_q & ~blank_q[idx_q]
               & (presc_q[PW-1 -: 4] <= bright_q);
        for (int i = 0; i < DIGITS; i++) begin
            an_d[i] = ~(active && (idx_q == 3'(i)));
        end
        seg_d = active ? hex7(cur) : 7'h7F;
        dpo_d = ~(active & dp_q[idx_q]);
    end

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            data_q   <= 32'h0;
            en_q     <= 1'b1;
            bright_q <= 4'hF;
            srst_q   <= 1'b0;
            blank_q  <= 8'h0;
            dp_q     <= 8'h0;
            presc_q  <= '0;
            idx_q    <= 3'd0;
            an_q     <= '1;
            seg_q    <= 7'h7F;
            dpo_q    <= 1'b1;
        end else begin
            data_q   <= data_d;
            en_q     <= en_d;
            bright_q <= bright_d;
            srst_q   <= srst_d;
            blank_q  <= blank_d;
            dp_q     <= dp_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dpo_q    <= dpo_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
`ifdef SEG7_DP_EN
    assign dp_o  = dpo_q;
`endif

endmodule
